countdown_timer_bcd: RTL and testbench

Parametrised multi-digit BCD countdown timer with load, start, pause and expiry signalling. It runs on the single system clock and advances on a one-cycle `tick` strobe from an external divider; it never uses a derived clock. Each digit has its own radix, so one block covers SS, MM:SS or longer formats. Digit outputs feed the existing seven-segment display mux directly.

---
 rtl/countdown_timer_bcd.sv | 109 ++++++++++
 tb/tb_countdown_timer_bcd.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// Multi-digit BCD countdown timer with per-digit radix, load/start/pause control
// and expiry signalling; advances on a single-cycle tick strobe.
module countdown_timer_bcd #(
  parameter int unsigned                  NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0]      MAX_VEC     = 16'h9959,
  parameter bit                           AUTO_RELOAD = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    zero,
  output logic                    done,
  output logic                    expired
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t         state;
  logic [W-1:0]   reload_q;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   count_dec;
  logic           borrow;

  // Saturate each preset digit to its radix maximum.
  always_comb begin
    load_clamped = load_value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > MAX_VEC[4*i +: 4]) begin
        load_clamped[4*i +: 4] = MAX_VEC[4*i +: 4];
      end
    end
  end

  // Ripple-borrow decrement; a zero digit that borrows wraps to its maximum.
  always_comb begin
    count_dec = count;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = MAX_VEC[4*i +: 4];
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  // Control FSM and counter; commands resolve as load > start > pause > tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      reload_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count    <= load_clamped;
        reload_q <= load_clamped;
        state    <= S_IDLE;
      end else if (start) begin
        if (!zero && state != S_RUN) begin
          state <= S_RUN;
        end
      end else if (pause) begin
        if (state == S_RUN) begin
          state <= S_PAUSED;
        end
      end else if (tick && state == S_RUN) begin
        if (zero) begin
          // Only reachable after an auto-reload expiry.
          if (AUTO_RELOAD && reload_q != '0) begin
            count <= reload_q;
          end else begin
            state <= S_EXPIRED;
          end
        end else begin
          count <= count_dec;
          if (count_dec == '0) begin
            done <= 1'b1;
            if (!AUTO_RELOAD) begin
              state <= S_EXPIRED;
            end
          end
        end
      end
    end
  end

  assign zero    = (count == '0);
  assign running = (state == S_RUN);
  assign expired = (state == S_EXPIRED);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed, table-driven bench for countdown_timer_bcd: a one-shot instance and
// an auto-reload instance share the stimulus; outputs are compared per cycle.
module tb_countdown_timer_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [15:0] count, count_ar;
  logic        running, zero, done, expired;
  logic        running_ar, zero_ar, done_ar, expired_ar;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd #(.NUM_DIGITS(4), .MAX_VEC(16'h9959), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count), .running(running), .zero(zero),
    .done(done), .expired(expired)
  );

  countdown_timer_bcd #(.NUM_DIGITS(4), .MAX_VEC(16'h9959), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_ar), .running(running_ar), .zero(zero_ar),
    .done(done_ar), .expired(expired_ar)
  );

  typedef struct {
    logic        rst, ld, st, ps, tk;
    logic [15:0] lv;
    logic [15:0] e_count;
    logic        e_run, e_zero, e_done, e_exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ld, st, ps, tk, input logic [15:0] lv,
                              input logic [15:0] c, input logic r, z, d, x);
    vec_t v;
    v.rst = rst; v.ld = ld; v.st = st; v.ps = ps; v.tk = tk; v.lv = lv;
    v.e_count = c; v.e_run = r; v.e_zero = z; v.e_done = d; v.e_exp = x;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic rst, ld, st, ps, tk, input logic [15:0] lv);
    reset = rst; load = ld; start = st; pause = ps; tick = tk; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got count=%h run/zero/done/exp=%b, expected count=%h run/zero/done/exp=%b",
               name, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  function automatic logic [19:0] obs();
    return {count, running, zero, done, expired};
  endfunction

  function automatic logic [19:0] obs_ar();
    return {count_ar, running_ar, zero_ar, done_ar, expired_ar};
  endfunction

  function automatic logic [19:0] ex(input logic [15:0] c, input logic r, z, d, x);
    return {c, r, z, d, x};
  endfunction

  int dones;

  initial begin
    //            rst ld st ps tk  load_val   count    run zero done exp
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h0005, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h7A8F, 16'h7959, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0009, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0008, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0007, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0007, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0007, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0007, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0006, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h0006, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0002, 16'h0002, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 16'h0002, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0042, 16'h0042, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 16'h0099, 16'h0000, 0, 1, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].tk, vecs[i].lv);
      check($sformatf("vec%0d", i), obs(),
            ex(vecs[i].e_count, vecs[i].e_run, vecs[i].e_zero, vecs[i].e_done, vecs[i].e_exp));
    end

    // Borrow across digits and expiry from 01:00.
    step(0, 1, 0, 0, 0, 16'h0100);
    step(0, 0, 1, 0, 0, 16'h0000);
    dones = 0;
    for (int t = 1; t <= 60; t++) begin
      step(0, 0, 0, 0, 1, 16'h0000);
      if (done) dones++;
      if (t == 1)  check("underflow_t1",  obs(), ex(16'h0059, 1, 0, 0, 0));
      if (t == 10) check("underflow_t10", obs(), ex(16'h0050, 1, 0, 0, 0));
      if (t == 59) check("underflow_t59", obs(), ex(16'h0001, 1, 0, 0, 0));
      if (t == 60) check("underflow_t60", obs(), ex(16'h0000, 0, 1, 1, 1));
    end
    step(0, 0, 0, 0, 0, 16'h0000);
    check("done_one_cycle", obs(), ex(16'h0000, 0, 1, 0, 1));
    step(0, 0, 0, 0, 1, 16'h0000);
    check("tick61_hold", obs(), ex(16'h0000, 0, 1, 0, 1));
    check("single_done", 20'(dones), 20'd1);

    // Auto-reload: three periods of 3 ticks plus a reload tick.
    step(1, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 0, 16'h0003);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("ar_start", obs_ar(), ex(16'h0003, 1, 0, 0, 0));
    dones = 0;
    for (int p = 0; p < 3; p++) begin
      for (int t = 1; t <= 3; t++) begin
        step(0, 0, 0, 0, 1, 16'h0000);
        if (done_ar) dones++;
        if (t == 1) check($sformatf("ar_p%0d_t1", p), obs_ar(), ex(16'h0002, 1, 0, 0, 0));
      end
      check($sformatf("ar_p%0d_zero", p), obs_ar(), ex(16'h0000, 1, 1, 1, 0));
      step(0, 0, 0, 0, 1, 16'h0000);
      check($sformatf("ar_p%0d_reload", p), obs_ar(), ex(16'h0003, 1, 0, 0, 0));
    end
    check("ar_done_count", 20'(dones), 20'd3);

    // Reset in the middle of a run.
    step(0, 1, 0, 0, 0, 16'h0230);
    step(0, 0, 1, 0, 0, 16'h0000);
    repeat (5) step(0, 0, 0, 0, 1, 16'h0000);
    check("midrun_count", obs(), ex(16'h0225, 1, 0, 0, 0));
    step(1, 0, 0, 0, 1, 16'h0000);
    check("midrun_reset", obs(), ex(16'h0000, 0, 1, 0, 0));
    check("midrun_reset_ar", obs_ar(), ex(16'h0000, 0, 1, 0, 0));
    step(0, 0, 1, 0, 0, 16'h0000);
    check("start_after_reset", obs(), ex(16'h0000, 0, 1, 0, 0));
    step(0, 0, 0, 0, 1, 16'h0000);
    check("start_after_reset_ar", obs_ar(), ex(16'h0000, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
